// File: rtl/multicycle_computer_if.sv
// Unified instruction/data memory port with a req/ack handshake.
// The core drives the request side; the memory answers with rdata/ack.
interface multicycle_computer_if #(
  parameter int AW = 8
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/multicycle_computer.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB over one req/ack memory port,
// with halt/fault states, memory-timeout watchdog, retire counter and debug register read.
module multicycle_computer #(
  parameter int          AW       = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int          TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  rstd,
  multicycle_computer_if.master mem,
  output logic [AW-1:0]         pc,
  output logic                  halted,
  output logic                  fault,
  output logic [31:0]           retire_cnt,
  input  logic [4:0]            dbg_ra,
  output logic [31:0]           dbg_rd
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_HALT  = 6'd63;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [31:0]    ir, a_q, b_q, aluout, alu_d, mdr;
  logic [31:0]    rf [32];
  logic [31:0]    retire_q;
  logic [TW-1:0]  tmo_cnt;
  logic           req_q, we_q, halted_q, fault_q;
  logic [AW-1:0]  addr_q;
  logic [31:0]    wdata_q;

  logic           retire, rf_we;
  logic [4:0]     rf_wa;
  logic [31:0]    rf_wd;
  logic           mem_done, mem_tmo;

  logic [5:0]     op, funct;
  logic [31:0]    simm, ea;
  logic [AW-1:0]  jt, boff;

  assign op    = ir[31:26];
  assign funct = ir[5:0];
  assign simm  = {{16{ir[15]}}, ir[15:0]};
  assign ea    = a_q + simm;
  assign jt    = AW'({ir[25:0], 2'b00});
  assign boff  = AW'({simm[29:0], 2'b00});

  assign mem_done = req_q & mem.mem_ack;
  assign mem_tmo  = req_q & ~mem.mem_ack & (tmo_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    alu_d   = aluout;
    retire  = 1'b0;
    rf_we   = 1'b0;
    rf_wa   = ir[20:16];
    rf_wd   = aluout;
    case (state_q)
      S_FETCH: begin
        if (mem_done) begin
          state_d = S_DECODE;
          pc_d    = pc_q + AW'(4);
        end else if (mem_tmo) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_RTYPE: begin
            state_d = S_WB;
            case (funct)
              FN_ADD:  alu_d = a_q + b_q;
              FN_SUB:  alu_d = a_q - b_q;
              FN_AND:  alu_d = a_q & b_q;
              FN_OR:   alu_d = a_q | b_q;
              FN_SLT:  alu_d = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
              default: state_d = S_FAULT;
            endcase
          end
          OP_ADDI: begin
            alu_d   = ea;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_d   = ea;
            state_d = (ea[1:0] != 2'b00) ? S_FAULT : S_MEM;
          end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = pc_q + boff;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_J: begin
            pc_d    = jt;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_HALT: begin
            retire  = 1'b1;
            state_d = S_HALT;
          end
          default: state_d = S_FAULT;
        endcase
      end
      S_MEM: begin
        if (mem_done) begin
          if (op == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (mem_tmo) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        rf_wa   = (op == OP_RTYPE) ? ir[15:11] : ir[20:16];
        rf_wd   = (op == OP_LW) ? mdr : aluout;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = state_q;
    endcase
  end

  // Bus outputs are registered from the next state, so the first FETCH after
  // reset spends one idle cycle before mem_req rises.
  always_ff @(posedge clk) begin
    if (rstd) begin
      state_q  <= S_FETCH;
      pc_q     <= AW'(RESET_PC);
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
      retire_q <= '0;
      tmo_cnt  <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      ir       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout   <= '0;
      mdr      <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      aluout  <= alu_d;
      if (state_q == S_FETCH && mem_done) ir <= mem.mem_rdata;
      if (state_q == S_DECODE) begin
        a_q <= rf[ir[25:21]];
        b_q <= rf[ir[20:16]];
      end
      if (state_q == S_MEM && mem_done) mdr <= mem.mem_rdata;
      if (rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;
      if (retire) retire_q <= retire_q + 32'd1;
      tmo_cnt <= (req_q && !mem.mem_ack && state_d == state_q) ? tmo_cnt + TW'(1) : '0;
      req_q   <= (state_d == S_FETCH) || (state_d == S_MEM);
      we_q    <= (state_d == S_MEM) && (op == OP_SW);
      if (state_d == S_FETCH) begin
        addr_q <= pc_d;
      end else if (state_d == S_MEM) begin
        addr_q  <= alu_d[AW-1:0];
        wdata_q <= b_q;
      end
      halted_q <= (state_d == S_HALT);
      fault_q  <= (state_d == S_FAULT);
    end
  end

  always_comb begin
    dbg_rd = '0;
    if (dbg_ra != 5'd0) dbg_rd = rf[dbg_ra];
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign pc            = pc_q;
  assign halted        = halted_q;
  assign fault         = fault_q;
  assign retire_cnt    = retire_q;

endmodule

// File: tb/tb_multicycle_computer.sv
// Self-checking bench for multicycle_computer: vector table, directed corner cases,
// and random programs checked against an instruction-level interpreter.
module tb_multicycle_computer;
  localparam int AW  = 8;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rstd = 1'b1;
  logic [AW-1:0] pc;
  logic          halted, fault;
  logic [31:0]   retire_cnt;
  logic [4:0]    dbg_ra = '0;
  logic [31:0]   dbg_rd;

  multicycle_computer_if #(.AW(AW)) bus ();

  multicycle_computer #(.AW(AW), .RESET_PC(0), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstd(rstd), .mem(bus), .pc(pc), .halted(halted), .fault(fault),
    .retire_cnt(retire_cnt), .dbg_ra(dbg_ra), .dbg_rd(dbg_rd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_w [64];
  bit  noack = 1'b0, rnd_lat = 1'b0, saw_write = 1'b0, addr_moved = 1'b0;
  int  lat = 0, wcnt = 0, cur_lat = 0, run_len = 0, cyc = 0;
  logic [AW-1:0] run_addr;
  logic [31:0] last_ret = '0;
  int  runs[$];
  int  ret_cyc[$];

  // memory responder and bus monitors, all at the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!bus.mem_req) begin
      bus.mem_ack = 1'b0;
      wcnt = 0;
    end else if (noack) begin
      bus.mem_ack = 1'b0;
    end else begin
      if (wcnt == 0) cur_lat = rnd_lat ? int'($urandom_range(0, 3)) : lat;
      if (wcnt >= cur_lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_w[bus.mem_addr[7:2]];
        if (bus.mem_we) mem_w[bus.mem_addr[7:2]] = bus.mem_wdata;
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
    end
    if (bus.mem_req && bus.mem_we) saw_write = 1'b1;
    if (bus.mem_req) begin
      if (run_len == 0) run_addr = bus.mem_addr;
      else if (bus.mem_addr != run_addr) addr_moved = 1'b1;
      run_len++;
    end else if (run_len > 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
    if (retire_cnt !== last_ret) begin
      ret_cyc.push_back(cyc);
      last_ret = retire_cnt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_i(input logic [5:0] fn, input int rd, input int rs, input int rt);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_i(input logic [5:0] op, input int rt, input int rs, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  localparam logic [31:0] HALT = {6'd63, 26'd0};

  function automatic int ivl(input int k);
    return (ret_cyc.size() > k) ? ret_cyc[k] - ret_cyc[k-1] : -1;
  endfunction

  task automatic clr_mon();
    runs.delete();
    ret_cyc.delete();
    run_len    = 0;
    addr_moved = 1'b0;
    saw_write  = 1'b0;
    last_ret   = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstd = 1'b1;
    @(negedge clk);
    rstd = 1'b0;
    #1;
    clr_mon();
  endtask

  task automatic load_prog(input logic [31:0] p[$]);
    for (int i = 0; i < 64; i++) mem_w[i] = '0;
    for (int i = 0; i < p.size(); i++) mem_w[i] = p[i];
  endtask

  task automatic run_to_end(input string name, input int budget);
    int n;
    n = 0;
    while (!(halted || fault) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, " finished"}, 32'(halted | fault), 32'd1);
  endtask

  task automatic rd_reg(input int r, output logic [31:0] v);
    @(negedge clk);
    dbg_ra = 5'(r);
    #1;
    v = dbg_rd;
  endtask

  // instruction-level reference interpreter
  logic [31:0] ref_r [32];
  logic [31:0] ref_m [64];
  logic [7:0]  ref_pc;
  int          ref_ret;
  bit          ref_halt, ref_fault;

  task automatic ref_run();
    logic [31:0] ir, a, b, simm, ea, v;
    logic [7:0]  p;
    bit          wr;
    int          dst;
    for (int i = 0; i < 32; i++) ref_r[i] = '0;
    p = '0; ref_ret = 0; ref_halt = 1'b0; ref_fault = 1'b0;
    for (int s = 0; s < 2000 && !ref_halt && !ref_fault; s++) begin
      ir   = ref_m[p[7:2]];
      p    = p + 8'd4;
      a    = ref_r[ir[25:21]];
      b    = ref_r[ir[20:16]];
      simm = {{16{ir[15]}}, ir[15:0]};
      ea   = a + simm;
      wr   = 1'b0; dst = int'(ir[20:16]); v = '0;
      case (ir[31:26])
        6'd0: begin
          wr = 1'b1; dst = int'(ir[15:11]);
          case (ir[5:0])
            6'd32: v = a + b;
            6'd34: v = a - b;
            6'd36: v = a & b;
            6'd37: v = a | b;
            6'd42: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin wr = 1'b0; ref_fault = 1'b1; end
          endcase
        end
        6'd8:  begin wr = 1'b1; v = ea; end
        6'd35: if (ea[1:0] != 0) ref_fault = 1'b1; else begin wr = 1'b1; v = ref_m[ea[7:2]]; end
        6'd43: if (ea[1:0] != 0) ref_fault = 1'b1; else ref_m[ea[7:2]] = b;
        6'd4:  if (a == b) p = p + 8'(simm * 4);
        6'd2:  p = 8'(ir * 4);
        6'd63: ref_halt = 1'b1;
        default: ref_fault = 1'b1;
      endcase
      if (wr && dst != 0) ref_r[dst] = v;
      if (!ref_fault) ref_ret++;
    end
    ref_pc = p;
  endtask

  task automatic check_vs_ref(input string tag);
    logic [31:0] v;
    int bad;
    chk({tag, " halted"}, 32'(halted), 32'(ref_halt));
    chk({tag, " fault"}, 32'(fault), 32'(ref_fault));
    chk({tag, " retire_cnt"}, retire_cnt, 32'(ref_ret));
    chk({tag, " pc"}, 32'(pc), 32'(ref_pc));
    for (int r = 1; r < 32; r++) begin
      rd_reg(r, v);
      chk($sformatf("%s reg%0d", tag, r), v, ref_r[r]);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem_w[i] !== ref_m[i]) bad++;
    chk({tag, " dmem words differing"}, 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm;
    int          lt;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        vt[10];
    logic [31:0] prog[$];
    logic [31:0] v;
    logic [5:0]  fns[5];
    int          n, hi, bad;

    vt[0] = '{6'd0, 6'd32, 32'd5,        32'd7,        16'h0,    0, 32'd12};
    vt[1] = '{6'd0, 6'd32, 32'hFFFFFFFF, 32'd1,        16'h0,    1, 32'd0};
    vt[2] = '{6'd0, 6'd34, 32'd5,        32'd7,        16'h0,    0, 32'hFFFFFFFE};
    vt[3] = '{6'd0, 6'd36, 32'hF0F0F0F0, 32'hFF00FF00, 16'h0,    2, 32'hF000F000};
    vt[4] = '{6'd0, 6'd37, 32'hF0F0F0F0, 32'h0F0F0000, 16'h0,    0, 32'hFFFFF0F0};
    vt[5] = '{6'd0, 6'd42, 32'hFFFFFFFF, 32'd1,        16'h0,    1, 32'd1};
    vt[6] = '{6'd0, 6'd42, 32'd1,        32'hFFFFFFFF, 16'h0,    0, 32'd0};
    vt[7] = '{6'd0, 6'd42, 32'h80000000, 32'h7FFFFFFF, 16'h0,    3, 32'd1};
    vt[8] = '{6'd8, 6'd0,  32'd10,       32'd0,        16'hFFFF, 0, 32'd9};
    vt[9] = '{6'd8, 6'd0,  32'h7FFFFFFF, 32'd0,        16'h0001, 1, 32'h80000000};
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};

    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 64; i++) mem_w[i] = '0;
    repeat (2) @(negedge clk);

    // zero-wait arithmetic program, including reset values and CPI
    prog = '{i_i(8, 1, 0, 16'd5), i_i(8, 2, 0, 16'd7), r_i(6'd32, 3, 1, 2), HALT};
    load_prog(prog);
    lat = 0;
    do_reset();
    chk("reset mem_req", 32'(bus.mem_req), 32'd0);
    chk("reset mem_we", 32'(bus.mem_we), 32'd0);
    chk("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("reset mem_wdata", bus.mem_wdata, 32'd0);
    chk("reset halted", 32'(halted), 32'd0);
    chk("reset fault", 32'(fault), 32'd0);
    chk("reset retire_cnt", retire_cnt, 32'd0);
    chk("reset pc", 32'(pc), 32'd0);
    run_to_end("t1", 300);
    rd_reg(3, v);
    chk("t1 r3", v, 32'd12);
    chk("t1 halted", 32'(halted), 32'd1);
    chk("t1 retire_cnt", retire_cnt, 32'd4);
    chk("t1 pc", 32'(pc), 32'h10);
    chk("t1 cpi addi", 32'(ivl(1)), 32'd4);
    chk("t1 cpi add", 32'(ivl(2)), 32'd4);
    chk("t1 cpi halt", 32'(ivl(3)), 32'd3);

    // three-cycle memory latency on both fetch and load
    prog = '{i_i(35, 4, 0, 16'd8), HALT, 32'hDEADBEEF};
    load_prog(prog);
    lat = 2;
    do_reset();
    run_to_end("t2", 300);
    rd_reg(4, v);
    chk("t2 r4", v, 32'hDEADBEEF);
    chk("t2 fetch req cycles", 32'((runs.size() > 0) ? runs[0] : -1), 32'd3);
    chk("t2 mem req cycles", 32'((runs.size() > 1) ? runs[1] : -1), 32'd3);
    chk("t2 addr stable", 32'(addr_moved), 32'd0);
    chk("t2 halted", 32'(halted), 32'd1);

    // loop with taken branch and jump
    prog = '{i_i(8, 1, 0, 16'd3), i_i(8, 1, 1, 16'hFFFF), i_i(4, 0, 1, 16'd1),
             {6'd2, 26'd1}, HALT};
    load_prog(prog);
    ref_m = mem_w;
    ref_run();
    lat = 1;
    do_reset();
    run_to_end("t3", 600);
    rd_reg(1, v);
    chk("t3 r1", v, 32'd0);
    check_vs_ref("t3");

    // watchdog: request never acknowledged
    prog = '{HALT};
    load_prog(prog);
    noack = 1'b1;
    do_reset();
    n = 0; hi = 0;
    while (!fault && n < 60) begin
      @(negedge clk);
      n++;
      if (!fault && bus.mem_req) hi++;
    end
    chk("t4 req cycles before fault", 32'(hi), 32'(TMO));
    chk("t4 fault", 32'(fault), 32'd1);
    chk("t4 req after fault", 32'(bus.mem_req), 32'd0);
    chk("t4 pc", 32'(pc), 32'd0);
    repeat (10) @(negedge clk);
    chk("t4 fault sticky", 32'(fault), 32'd1);
    chk("t4 req stays low", 32'(bus.mem_req), 32'd0);
    noack = 1'b0;
    do_reset();
    chk("t4 fault cleared", 32'(fault), 32'd0);

    // misaligned store, then an illegal opcode
    prog = '{i_i(43, 2, 0, 16'd2), HALT};
    load_prog(prog);
    lat = 0;
    do_reset();
    run_to_end("t5a", 200);
    chk("t5a fault", 32'(fault), 32'd1);
    chk("t5a no write cycle", 32'(saw_write), 32'd0);
    chk("t5a retire_cnt", retire_cnt, 32'd0);
    prog = '{i_i(8, 1, 0, 16'd1), 32'hF8000000, HALT};
    load_prog(prog);
    do_reset();
    run_to_end("t5b", 200);
    chk("t5b fault", 32'(fault), 32'd1);
    chk("t5b halted", 32'(halted), 32'd0);
    chk("t5b retire_cnt", retire_cnt, 32'd1);
    rd_reg(1, v);
    chk("t5b r1", v, 32'd1);

    // reset while a store waits for its ack
    prog = '{i_i(8, 2, 0, 16'h55), i_i(43, 2, 0, 16'h80), HALT};
    load_prog(prog);
    lat = 8;
    do_reset();
    n = 0;
    while (!(bus.mem_req && bus.mem_we) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6 store issued", 32'(bus.mem_req && bus.mem_we), 32'd1);
    rstd = 1'b1;
    @(negedge clk);
    rstd = 1'b0;
    #1;
    clr_mon();
    lat = 0;
    chk("t6 req after reset", 32'(bus.mem_req), 32'd0);
    chk("t6 pc after reset", 32'(pc), 32'd0);
    chk("t6 retire after reset", retire_cnt, 32'd0);
    chk("t6 mem untouched", mem_w[32], 32'd0);
    rd_reg(2, v);
    chk("t6 r2 cleared", v, 32'd0);
    run_to_end("t6", 300);
    rd_reg(2, v);
    chk("t6 r2", v, 32'h55);
    chk("t6 stored word", mem_w[32], 32'h55);
    chk("t6 retire_cnt", retire_cnt, 32'd3);
    chk("t6 cpi sw", 32'(ivl(1)), 32'd4);
    prog = '{i_i(8, 0, 0, 16'd9), r_i(6'd32, 3, 0, 0), i_i(8, 4, 0, 16'd1), HALT};
    load_prog(prog);
    do_reset();
    run_to_end("t7", 300);
    rd_reg(0, v);
    chk("t7 r0", v, 32'd0);
    rd_reg(3, v);
    chk("t7 r3 from r0", v, 32'd0);
    chk("t7 retire_cnt", retire_cnt, 32'd4);

    // table-driven ALU vectors
    for (int k = 0; k < 10; k++) begin
      prog = '{i_i(35, 1, 0, 16'h80), i_i(35, 2, 0, 16'h84),
               (vt[k].op == 6'd0) ? r_i(vt[k].fn, 3, 1, 2) : i_i(vt[k].op, 3, 1, vt[k].imm),
               HALT};
      load_prog(prog);
      mem_w[32] = vt[k].a;
      mem_w[33] = vt[k].b;
      lat = vt[k].lt;
      do_reset();
      run_to_end($sformatf("vec%0d", k), 400);
      rd_reg(3, v);
      chk($sformatf("vec%0d r3", k), v, vt[k].exp);
      chk($sformatf("vec%0d retire_cnt", k), retire_cnt, 32'd4);
      if (vt[k].lt == 0) chk($sformatf("vec%0d cpi lw", k), 32'(ivl(1)), 32'd5);
    end

    // random programs with random per-request latency
    rnd_lat = 1'b1;
    for (int t = 0; t < 6; t++) begin
      prog.delete();
      for (int k = 0; k < 14; k++) begin
        case ($urandom_range(0, 3))
          0: prog.push_back(i_i(8, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 16'($urandom)));
          1: prog.push_back(r_i(fns[$urandom_range(0, 4)], int'($urandom_range(0, 7)),
                                int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
          2: prog.push_back(i_i(35, int'($urandom_range(0, 7)), 0, 16'(32'h80 + 4 * $urandom_range(0, 15))));
          default: prog.push_back(i_i(43, int'($urandom_range(0, 7)), 0, 16'(32'h80 + 4 * $urandom_range(0, 15))));
        endcase
      end
      prog.push_back(HALT);
      load_prog(prog);
      for (int i = 32; i < 48; i++) mem_w[i] = $urandom;
      ref_m = mem_w;
      ref_run();
      do_reset();
      run_to_end($sformatf("rnd%0d", t), 2000);
      check_vs_ref($sformatf("rnd%0d", t));
    end
    rnd_lat = 1'b0;

    bad = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
